fwd_sched: RTL and testbench

- Forwarding/hazard scheduler for the pipelined RISC-V core.
- Tracks destination registers of in-flight instructions in its own EX/MEM/WB shadow pipeline.
- Produces the registered 2-bit selects for the two 3:1 ALU operand muxes: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- Generates the load-use stall and bubble; sits beside the ID/EX pipeline register.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_sched_if.sv | 50 +++++
 rtl/fwd_sel_calc.sv | 25 ++
 rtl/fwd_sched.sv | 130 +++++++++++++
 tb/tb_fwd_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard scheduler: operand-mux select codes
// and the shadow-pipeline stage entry.
package fwd_pkg;

   localparam int FWD_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic [FWD_AW-1:0] rd;
      logic              wr;
      logic              ld;
   } stage_t;

   localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/fwd_sched_if.sv
// Pipeline <-> forwarding scheduler signal bundle. The stall_cnt/fwd_cnt
// statistics outputs exist only when FWD_STATS_EN is defined.
interface fwd_sched_if #(
   parameter int REG_AW = 5
`ifdef FWD_STATS_EN
   , parameter int CNT_W = 16
`endif
);

   logic              hold;
   logic              flush;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              stall;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [REG_AW-1:0] ex_rd;
   logic [REG_AW-1:0] mem_rd;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_write;
`ifdef FWD_STATS_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  fwd_cnt;
`endif

   modport master (
      output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read,
      input  stall, fwd_a_sel, fwd_b_sel, ex_rd, mem_rd, wb_rd, wb_reg_write
`ifdef FWD_STATS_EN
      , input stall_cnt, fwd_cnt
`endif
   );

   modport slave (
      input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read,
      output stall, fwd_a_sel, fwd_b_sel, ex_rd, mem_rd, wb_rd, wb_reg_write
`ifdef FWD_STATS_EN
      , output stall_cnt, fwd_cnt
`endif
   );

endinterface

// File: rtl/fwd_sel_calc.sv
// Operand forwarding select for one source register: the youngest in-flight
// producer wins, x0 never forwards.
module fwd_sel_calc
   import fwd_pkg::*;
(
   input  logic [FWD_AW-1:0] rs,
   input  logic              use_rs,
   input  stage_t            ex,
   input  stage_t            mem,
   output fwd_sel_e          sel
);

   always_comb begin
      sel = FWD_RF;
      if (use_rs && (rs != '0)) begin
         // Whatever sits in EX now will be in MEM when the consumer reaches EX.
         if (ex.wr && (ex.rd == rs)) begin
            sel = FWD_EXMEM;
         end else if (mem.wr && (mem.rd == rs)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/fwd_sched.sv
// Forwarding/hazard scheduler: EX/MEM/WB shadow of destination registers,
// registered operand-mux selects and the load-use stall.
// Optional build macro: FWD_STATS_EN adds saturating stall/forward counters.
module fwd_sched
   import fwd_pkg::*;
#(
   parameter int REG_AW = FWD_AW
`ifdef FWD_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input logic        clk,
   input logic        rst,
   fwd_sched_if.slave bus
);

   // Handshake: an ID instruction is accepted on an edge where id_valid=1,
   // stall=0, flush=0 and hold=0; with stall=1 the front end must keep the
   // same instruction presented in ID, and hold=1 freezes every register.
   logic [REG_AW-1:0] rs1_w;
   logic [REG_AW-1:0] rs2_w;
   logic              stall;
   logic              bubble;
   stage_t            id_entry;
   stage_t            ex_q, ex_d;
   stage_t            mem_q, mem_d;
   stage_t            wb_q, wb_d;
   fwd_sel_e          calc_a, calc_b;
   fwd_sel_e          sel_a_q, sel_a_d;
   fwd_sel_e          sel_b_q, sel_b_d;

   assign rs1_w = bus.id_rs1;
   assign rs2_w = bus.id_rs2;

   fwd_sel_calc u_sel_a (
      .rs     (rs1_w),
      .use_rs (bus.id_use_rs1),
      .ex     (ex_q),
      .mem    (mem_q),
      .sel    (calc_a)
   );

   fwd_sel_calc u_sel_b (
      .rs     (rs2_w),
      .use_rs (bus.id_use_rs2),
      .ex     (ex_q),
      .mem    (mem_q),
      .sel    (calc_b)
   );

   always_comb begin
      stall = bus.id_valid & ~bus.flush & ex_q.ld & (ex_q.rd != '0) &
              ((bus.id_use_rs1 & (rs1_w == ex_q.rd)) |
               (bus.id_use_rs2 & (rs2_w == ex_q.rd)));
      bubble   = ~bus.id_valid | stall | bus.flush;
      id_entry = BUBBLE;
      if (!bubble) begin
         id_entry = '{rd: bus.id_rd, wr: bus.id_reg_write, ld: bus.id_mem_read};
      end

      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (!bus.hold) begin
         ex_d    = id_entry;
         mem_d   = ex_q;
         wb_d    = mem_q;
         sel_a_d = bubble ? FWD_RF : calc_a;
         sel_b_d = bubble ? FWD_RF : calc_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= BUBBLE;
         mem_q   <= BUBBLE;
         wb_q    <= BUBBLE;
         sel_a_q <= FWD_RF;
         sel_b_q <= FWD_RF;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign bus.stall        = stall;
   assign bus.fwd_a_sel    = sel_a_q;
   assign bus.fwd_b_sel    = sel_b_q;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.mem_rd       = mem_q.rd;
   assign bus.wb_rd        = wb_q.rd;
   assign bus.wb_reg_write = wb_q.wr;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (!bus.hold) begin
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (!bubble && ((calc_a != FWD_RF) || (calc_b != FWD_RF)) && !(&fwd_cnt_q)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_sched.sv
// Directed bench for fwd_sched: each driven cycle pushes the hand-computed
// outputs expected during that cycle; a monitor pops and compares at negedge.
module tb_fwd_sched;

   localparam int AW = 5;
   localparam int W  = 21;
`ifdef FWD_STATS_EN
   localparam int CNT_W = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;

   fwd_sched_if #(
      .REG_AW (AW)
`ifdef FWD_STATS_EN
      , .CNT_W (CNT_W)
`endif
   ) bus ();

   fwd_sched #(
      .REG_AW (AW)
`ifdef FWD_STATS_EN
      , .CNT_W (CNT_W)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running required done");
      $fatal(1);
   end

   function automatic logic [W-1:0] pack(input int st, input int a, input int b,
                                         input int ex, input int mem, input int wb,
                                         input int wbw);
      return {1'(st), 2'(a), 2'(b), 5'(ex), 5'(mem), 5'(wb), 1'(wbw)};
   endfunction

   // driver tasks
   task automatic drv(input int r, input int h, input int f, input int v,
                      input int rd, input int wr, input int ld,
                      input int rs1, input int u1, input int rs2, input int u2);
      @(posedge clk);
      #1;
      rst              = 1'(r);
      bus.hold         = 1'(h);
      bus.flush        = 1'(f);
      bus.id_valid     = 1'(v);
      bus.id_rd        = 5'(rd);
      bus.id_reg_write = 1'(wr);
      bus.id_mem_read  = 1'(ld);
      bus.id_rs1       = 5'(rs1);
      bus.id_use_rs1   = 1'(u1);
      bus.id_rs2       = 5'(rs2);
      bus.id_use_rs2   = 1'(u2);
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic exr(input string nm, input int st, input int a, input int b,
                      input int ex, input int mem, input int wb, input int wbw);
      exp_q.push_back(pack(st, a, b, ex, mem, wb, wbw));
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   initial begin
      logic [W-1:0] e, g;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {bus.stall, bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_rd, bus.mem_rd,
                  bus.wb_rd, bus.wb_reg_write};
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL %s: got stall=%0b a=%b b=%b ex=%0d mem=%0d wb=%0d wbw=%0b, required stall=%0b a=%b b=%b ex=%0d mem=%0d wb=%0d wbw=%0b",
                        nm, g[20], g[19:18], g[17:16], g[15:11], g[10:6], g[5:1], g[0],
                        e[20], e[19:18], e[17:16], e[15:11], e[10:6], e[5:1], e[0]);
            end
         end
      end
   end

`ifdef FWD_STATS_EN
   task automatic chk_cnt(input string nm, input int st_exp, input int fw_exp);
      @(negedge clk);
      n_tests++;
      if (bus.stall_cnt !== CNT_W'(st_exp) || bus.fwd_cnt !== CNT_W'(fw_exp)) begin
         n_fail++;
         $display("FAIL %s: got stall_cnt=%0d fwd_cnt=%0d, required stall_cnt=%0d fwd_cnt=%0d",
                  nm, bus.stall_cnt, bus.fwd_cnt, st_exp, fw_exp);
      end
   endtask
`endif

   // stimulus
   initial begin
      bus.hold = 0; bus.flush = 0; bus.id_valid = 0; bus.id_rd = 0;
      bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_rs1 = 0; bus.id_use_rs1 = 0;
      bus.id_rs2 = 0; bus.id_use_rs2 = 0;
      repeat (2) @(posedge clk);

      idle();                                  exr("reset", 0, 0, 0, 0, 0, 0, 0);
      // back-to-back ALU dependency
      drv(0,0,0,1, 5,1,0, 1,1,2,1);            exr("b2b_add", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,0,1, 6,1,0, 5,1,2,1);            exr("b2b_sub_id", 0, 0, 0, 5, 0, 0, 0);
      idle();                                  exr("b2b_sub_ex", 0, 1, 0, 6, 5, 0, 0);
      idle();                                  exr("b2b_drain1", 0, 0, 0, 0, 6, 5, 1);
      idle();                                  exr("b2b_drain2", 0, 0, 0, 0, 0, 6, 1);
      // distance-2 dependency, rs2 then both operands
      drv(0,0,0,1, 7,1,0, 1,1,0,0);            exr("d2_writer", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,0,1, 8,1,0, 1,1,2,1);            exr("d2_gap", 0, 0, 0, 7, 0, 0, 0);
      drv(0,0,0,1, 9,1,0, 1,1,7,1);            exr("d2_reader_id", 0, 0, 0, 8, 7, 0, 0);
      drv(0,0,0,1, 7,1,0, 0,0,0,0);            exr("d2_rs2_ex", 0, 0, 2, 9, 8, 7, 1);
      drv(0,0,0,1, 11,1,0, 1,1,2,1);           exr("d2b_gap", 0, 0, 0, 7, 9, 8, 1);
      drv(0,0,0,1, 12,1,0, 7,1,7,1);           exr("d2b_reader_id", 0, 0, 0, 11, 7, 9, 1);
      idle();                                  exr("d2b_both_ex", 0, 2, 2, 12, 11, 7, 1);
      idle();                                  exr("d2b_drain1", 0, 0, 0, 0, 12, 11, 1);
      idle();                                  exr("d2b_drain2", 0, 0, 0, 0, 0, 12, 1);
      // load-use
      drv(0,0,0,1, 3,1,1, 1,1,0,0);            exr("lu_lw", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,0,1, 13,1,0, 3,1,2,1);           exr("lu_stall", 1, 0, 0, 3, 0, 0, 0);
      drv(0,0,0,1, 13,1,0, 3,1,2,1);           exr("lu_bubble", 0, 0, 0, 0, 3, 0, 0);
      idle();                                  exr("lu_fwd", 0, 2, 0, 13, 0, 3, 1);
      idle();                                  exr("lu_drain1", 0, 0, 0, 0, 13, 0, 0);
      idle();                                  exr("lu_drain2", 0, 0, 0, 0, 0, 13, 1);
      // x0: a load to x0 neither stalls nor forwards
      drv(0,0,0,1, 0,1,1, 1,1,0,0);            exr("x0_writer", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,0,1, 14,1,0, 0,1,0,1);           exr("x0_reader_id", 0, 0, 0, 0, 0, 0, 0);
      idle();                                  exr("x0_reader_ex", 0, 0, 0, 14, 0, 0, 0);
      idle();                                  exr("x0_drain1", 0, 0, 0, 0, 14, 0, 1);
      idle();                                  exr("x0_drain2", 0, 0, 0, 0, 0, 14, 1);
      // youngest producer wins
      drv(0,0,0,1, 4,1,0, 1,1,0,0);            exr("prio_w1", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,0,1, 4,1,0, 2,1,0,0);            exr("prio_w2", 0, 0, 0, 4, 0, 0, 0);
      drv(0,0,0,1, 15,1,0, 4,1,2,1);           exr("prio_reader_id", 0, 0, 0, 4, 4, 0, 0);
      idle();                                  exr("prio_reader_ex", 0, 1, 0, 15, 4, 4, 1);
      idle();                                  exr("prio_drain1", 0, 0, 0, 0, 15, 4, 1);
      idle();                                  exr("prio_drain2", 0, 0, 0, 0, 0, 15, 1);
      // flush beats load-use stall
      drv(0,0,0,1, 3,1,1, 1,1,0,0);            exr("flush_lw", 0, 0, 0, 0, 0, 0, 0);
      drv(0,0,1,1, 16,1,0, 3,1,0,0);           exr("flush_no_stall", 0, 0, 0, 3, 0, 0, 0);
      idle();                                  exr("flush_bubble", 0, 0, 0, 0, 3, 0, 0);
      // hold freezes everything
      drv(0,0,0,1, 20,1,0, 1,1,0,0);           exr("hold_w1", 0, 0, 0, 0, 0, 3, 1);
      drv(0,0,0,1, 21,1,0, 20,1,2,1);          exr("hold_w2", 0, 0, 0, 20, 0, 0, 0);
      drv(0,0,0,1, 22,1,0, 21,1,20,1);         exr("hold_w3", 0, 1, 0, 21, 20, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drv(0,1,0,1, 23,1,0, 22,1,0,0);       exr("hold_frozen", 0, 1, 2, 22, 21, 20, 1);
      end
      drv(0,0,0,1, 24,1,0, 22,1,0,0);          exr("hold_release", 0, 1, 2, 22, 21, 20, 1);
      // reset mid-stream
      drv(1,0,0,0, 0,0,0, 0,0,0,0);            exr("pre_reset", 0, 1, 0, 24, 22, 21, 1);
      idle();                                  exr("mid_reset", 0, 0, 0, 0, 0, 0, 0);
      // four load-use pairs
      for (int k = 0; k < 4; k++) begin
         drv(0,0,0,1, 3,1,1, 1,1,0,0);
         if (k == 0) exr("pair_lw", 0, 0, 0, 0, 0, 0, 0);
         else        exr("pair_lw", 0, 2, 0, 13, 0, 3, 1);
         drv(0,0,0,1, 13,1,0, 3,1,2,1);
         exr("pair_stall", 1, 0, 0, 3, (k == 0) ? 0 : 13, 0, 0);
         drv(0,0,0,1, 13,1,0, 3,1,2,1);
         exr("pair_resume", 0, 0, 0, 0, 3, (k == 0) ? 0 : 13, (k == 0) ? 0 : 1);
`ifdef FWD_STATS_EN
         if (k == 2) chk_cnt("stats_three_stalls", 3, 2);
         if (k == 3) chk_cnt("stats_saturated", 3, 3);
`endif
      end
      idle();                                  exr("pair_fwd", 0, 2, 0, 13, 0, 3, 1);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
